sgf_serial_addsub: RTL

- Multi-cycle digit-serial adder/subtractor for significand datapaths in the Add-Subt unit.
- Each digit uses the three-input XOR sum with a registered carry between cycles. This is the sequential counterpart of the single-bit sum cell.
- Trades area for latency: D result bits per clock, LSB first, with a start/ready handshake toward the Add-Subt control FSM.

---
 rtl/sgf_serial_addsub_if.sv | 25 ++
 rtl/sgf_serial_addsub.sv | 109 ++++++++++
 2 files changed

// File: rtl/sgf_serial_addsub_if.sv
// rtl/sgf_serial_addsub_if.sv - start/ready handshake and operand/result bundle for the digit-serial adder
interface sgf_serial_addsub_if #(
  parameter int W = 26
);
  logic         start_i;
  logic         op_i;
  logic [W-1:0] A_i;
  logic [W-1:0] B_i;
  logic         busy_o;
  logic         ready_o;
  logic [W-1:0] S_o;
  logic         C_o;

  // Control FSM side: issues requests, consumes results
  modport master (
    output start_i, op_i, A_i, B_i,
    input  busy_o, ready_o, S_o, C_o
  );

  // Arithmetic unit side
  modport slave (
    input  start_i, op_i, A_i, B_i,
    output busy_o, ready_o, S_o, C_o
  );
endinterface

// File: rtl/sgf_serial_addsub.sv
// rtl/sgf_serial_addsub.sv - digit-serial significand adder/subtractor, D bits per clock, LSB first
module sgf_serial_addsub #(
  parameter int W = 26,
  parameter int D = 1
) (
  input  logic                clk,
  input  logic                rst,
  sgf_serial_addsub_if.slave  bus
);

  localparam int N  = W / D;
  localparam int CW = (N < 1) ? 1 : $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sh;
  logic [W-1:0]  r_s;
  logic          r_c;

  logic [D-1:0]  w_sum;
  logic          w_cout;
  logic [W-1:0]  w_sh_next;
  logic          w_accept;
  logic          w_last;

  assign w_accept = (r_state == S_IDLE) && bus.start_i;
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(N - 1));

  // Ripple the registered carry through the low D bits of the operand registers
  always_comb begin : digit_adder
    logic v_c;
    v_c   = r_carry;
    w_sum = '0;
    for (int i = 0; i < D; i++) begin
      w_sum[i] = r_a[i] ^ r_b[i] ^ v_c;
      v_c      = (r_a[i] & r_b[i]) | (r_a[i] & v_c) | (r_b[i] & v_c);
    end
    w_cout = v_c;
  end

  // New digit enters at the top; after N steps the LSB digit has reached bit 0
  assign w_sh_next = (r_sh >> D) | (W'(w_sum) << (W - D));

  // Control state and digit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand capture on accept; subtraction becomes A + ~B + 1 via the initial carry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sh    <= '0;
    end else if (w_accept) begin
      r_a     <= bus.A_i;
      r_b     <= bus.op_i ? ~bus.B_i : bus.B_i;
      r_carry <= bus.op_i;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> D;
      r_b     <= r_b >> D;
      r_carry <= w_cout;
      r_sh    <= w_sh_next;
    end
  end

  // Result registers only move on the completion edge so the caller sees a stable value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s <= '0;
      r_c <= 1'b0;
    end else if (w_last) begin
      r_s <= w_sh_next;
      r_c <= w_cout;
    end
  end

  assign bus.busy_o  = (r_state == S_RUN);
  assign bus.ready_o = (r_state == S_DONE);
  assign bus.S_o     = r_s;
  assign bus.C_o     = r_c;

endmodule
